pm_mac_accum: RTL and testbench

//  Multiply-accumulate stage built around the pm8 8x8 partial-product multiplier.
//  - Accepts a frame of LEN operand pairs (a,b) over a valid/ready input.
//  - Sums the 16-bit products into an ACC_W-bit accumulator.
//  - Presents the total on a valid/ready output.
//  - Sits between the operand source and the result consumer (dot-product / filter tap).

---
 rtl/pm_acc_pkg.sv | 26 ++
 rtl/pm_mac_accum_pm8.sv | 18 +
 rtl/pm_mac_accum.sv | 99 +++++++++
 tb/tb_pm_mac_accum.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pm_acc_pkg.sv
// Shared types, defaults and the accumulate helper for pm_mac_accum.
// Optional feature macro: PM_ACC_SAT_EN (saturating accumulator).
package pm_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned ACC_W_DEF = 20;
    localparam int unsigned CNT_W_DEF = 8;

    // Adds p to acc at width w (w <= 63); returns {carry out of bit w-1, w-bit sum}.
    // Any clamping on carry is left to the caller.
    function automatic logic [64:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] p,
                                            input int unsigned w);
        logic [64:0] full;
        logic [63:0] mask;
        full = {1'b0, acc} + {1'b0, p};
        mask = (64'd1 << w) - 64'd1;
        return {full[w], full[63:0] & mask};
    endfunction

endpackage

// File: rtl/pm_mac_accum_pm8.sv
// pm8: unsigned 8x8 partial-product multiplier, purely combinational.
module pm8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    // Sum the shifted multiplicand for every set multiplier bit.
    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p + (16'(a) << i);
            end
        end
    end

endmodule

// File: rtl/pm_mac_accum.sv
// pm_mac_accum: frame-based multiply-accumulate over valid/ready handshakes.
// Optional feature macro: PM_ACC_SAT_EN (clamp accumulator on carry instead of wrapping).
module pm_mac_accum
    import pm_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, cnt_q, len_eff, cnt_inc;
    logic [ACC_W-1:0] acc_q, acc_nxt;
    logic [15:0]      prod;
    logic [64:0]      add_res;
    logic             ovf_q, carry, beat;

    pm8 u_pm8 (
        .a (a),
        .b (b),
        .p (prod)
    );

    assign in_ready  = (state_q != DONE);
    assign beat      = in_valid && in_ready;
    assign len_eff   = (len == '0) ? CNT_W'(1) : len;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    // Next accumulator value and carry for an ACC-state beat.
    always_comb begin
        add_res = sat_add(64'(acc_q), 64'(prod), ACC_W);
        // Bits above ACC_W are masked to zero by the helper; folding them in
        // keeps the carry definition independent of ACC_W.
        carry   = add_res[64] | (|add_res[63:ACC_W]);
`ifdef PM_ACC_SAT_EN
        acc_nxt = (carry || ovf_q) ? '1 : add_res[ACC_W-1:0];
`else
        acc_nxt = add_res[ACC_W-1:0];
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame start, last-beat detection, result handoff.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (beat) state_d = (len_eff == CNT_W'(1)) ? DONE : ACC;
            ACC:  if (beat && (cnt_inc == len_q)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: frame length capture, beat counter, accumulator, sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (beat) begin
            if (state_q == IDLE) begin
                len_q <= len_eff;
                cnt_q <= CNT_W'(1);
                acc_q <= ACC_W'(prod);
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_inc;
                acc_q <= acc_nxt;
                ovf_q <= ovf_q | carry;
            end
        end
    end

endmodule

// File: tb/tb_pm_mac_accum.sv
// Self-checking bench for pm_mac_accum: directed frames plus randomized frames
// checked against an arithmetic reference model.
module tb_pm_mac_accum;

    localparam int unsigned ACC_W = 20;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       a = '0;
    logic [7:0]       b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int unsigned total_n = 0;
    int unsigned bad_n   = 0;
    int unsigned qa[$];
    int unsigned qb[$];

    pm_mac_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_n++;
        if (obs !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives the frame held in qa/qb, then checks the result and the DONE hold/handoff.
    task automatic run_frame(input int unsigned ln, input int unsigned hold, input bit gaps);
        int unsigned      n;
        longint unsigned  total;
        longint unsigned  maxv;
        logic [ACC_W-1:0] exp_sum;
        bit               exp_ovf;
        n     = (ln == 0) ? 1 : ln;
        maxv  = (64'd1 << ACC_W) - 1;
        total = 0;
        for (int i = 0; i < int'(n); i++) total += longint'(qa[i] * qb[i]);
        exp_ovf = (total > maxv);
`ifdef PM_ACC_SAT_EN
        exp_sum = exp_ovf ? '1 : ACC_W'(total);
`else
        exp_sum = ACC_W'(total);
`endif
        for (int i = 0; i < int'(n); i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            chk("in_ready_beat", in_ready, 1);
            in_valid = 1'b1;
            a   = 8'(qa[i]);
            b   = 8'(qb[i]);
            len = (i == 0) ? CNT_W'(ln) : CNT_W'($urandom_range(255));
            @(posedge clk); #1;
            if (i < int'(n) - 1) chk("early_valid", out_valid, 0);
        end
        // Junk operands while DONE must be ignored.
        a = 8'($urandom_range(255));
        b = 8'($urandom_range(255));
        chk("out_valid", out_valid, 1);
        chk("out_sum", out_sum, exp_sum);
        chk("out_count", out_count, n);
        chk("out_ovf", out_ovf, exp_ovf);
        chk("in_ready_done", in_ready, 0);
        for (int h = 0; h < int'(hold); h++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, exp_sum);
            chk("hold_count", out_count, n);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_count", out_count, 0);
        chk("rst_ovf", out_ovf, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single beat, maximum product.
        qa = {255}; qb = {255};
        run_frame(1, 0, 1'b0);

        // Four-beat frame, immediate release.
        qa = {3, 10, 0, 255}; qb = {5, 10, 200, 1};
        run_frame(4, 0, 1'b0);

        // Same frame, consumer stalls for 5 cycles.
        run_frame(4, 5, 1'b0);

        // Overflow frame: 20 x 65025 exceeds 2^20-1.
        qa.delete(); qb.delete();
        for (int i = 0; i < 20; i++) begin qa.push_back(255); qb.push_back(255); end
        run_frame(20, 1, 1'b0);

        // Reset in the middle of a frame.
        qa = {2, 4}; qb = {3, 5};
        len = 4; in_valid = 1'b1;
        a = 8'd2; b = 8'd3;
        @(posedge clk); #1;
        a = 8'd4; b = 8'd5;
        @(posedge clk); #1;
        chk("mid_count", out_count, 2);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", out_sum, 0);
        chk("midrst_count", out_count, 0);
        chk("midrst_ovf", out_ovf, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(2, 0, 1'b0);

        // len=0 behaves as a one-beat frame.
        qa = {7}; qb = {6};
        run_frame(0, 0, 1'b0);

        // Randomized frames with gaps, stalls and saturating operands.
        for (int f = 0; f < 40; f++) begin
            int unsigned ln;
            ln = $urandom_range(24);
            qa.delete(); qb.delete();
            for (int i = 0; i < 25; i++) begin
                qa.push_back(($urandom_range(3) == 0) ? 255 : $urandom_range(255));
                qb.push_back(($urandom_range(3) == 0) ? 255 : $urandom_range(255));
            end
            run_frame(ln, $urandom_range(3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
